// File: rtl/bin_to_bcd_pkg.sv
// rtl/bin_to_bcd_pkg.sv - shared constants and sizing helper for the binary-to-BCD converter
package bin_to_bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL = 4'd3;

    // Enough decimal digits for any bin_width-bit value (log10(2) is just over 0.3).
    function automatic int default_bcd_digits(input int bin_width);
        return (bin_width * 3) / 10 + 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_add3.sv
// rtl/bin_to_bcd_add3.sv - single-digit double-dabble correction (add 3 when digit >= 5)
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + ADD3_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - binary to packed BCD converter with valid/ready handshake
// BIN_TO_BCD_SEQ_EN selects the iterative engine; default is the unrolled array.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int bin_width  = 8,
    parameter int bcd_digits = default_bcd_digits(bin_width)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [bin_width-1:0]              bin,
    output logic                              out_valid,
    output logic [BCD_DIGIT_W*bcd_digits-1:0] bcd,
    output logic                              overflow
);

    localparam int BCD_W = BCD_DIGIT_W * bcd_digits;

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;

    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign overflow  = overflow_q;

`ifdef BIN_TO_BCD_SEQ_EN

    localparam int CNT_W = $clog2(bin_width) + 1;

    logic                 busy_q, busy_d;
    logic [bin_width-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]     digits_q, digits_d;
    logic                 ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     adj;
    logic [BCD_W-1:0]     step_digits;
    logic                 step_ovf;

    genvar d;
    generate
        for (d = 0; d < bcd_digits; d++) begin : g_digit
            bcd_add3 u_add3 (
                .din  (digits_q[BCD_DIGIT_W*d +: BCD_DIGIT_W]),
                .dout (adj[BCD_DIGIT_W*d +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The bit leaving the top digit would be the carry into a digit we do not keep.
    assign step_digits = {adj[BCD_W-2:0], shift_q[bin_width-1]};
    assign step_ovf    = ovf_acc_q | adj[BCD_W-1];
    assign in_ready    = ~rst & ~busy_q;

    always_comb begin
        busy_d      = busy_q;
        shift_d     = shift_q;
        digits_d    = digits_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (busy_q) begin
            digits_d  = step_digits;
            ovf_acc_d = step_ovf;
            shift_d   = shift_q << 1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(bin_width - 1)) begin
                busy_d      = 1'b0;
                bcd_d       = step_digits;
                overflow_d  = step_ovf;
                out_valid_d = 1'b1;
            end
        end else if (in_valid && in_ready) begin
            busy_d    = 1'b1;
            shift_d   = bin;
            digits_d  = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            shift_q     <= '0;
            digits_q    <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            shift_q     <= shift_d;
            digits_q    <= digits_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

`else

    logic [bin_width:0][BCD_W-1:0]   stg;
    logic [bin_width-1:0][BCD_W-1:0] adj;
    logic [bin_width:0]              ovf_chain;

    assign stg[0]       = '0;
    assign ovf_chain[0] = 1'b0;

    genvar s, d;
    generate
        for (s = 0; s < bin_width; s++) begin : g_stage
            for (d = 0; d < bcd_digits; d++) begin : g_digit
                bcd_add3 u_add3 (
                    .din  (stg[s][BCD_DIGIT_W*d +: BCD_DIGIT_W]),
                    .dout (adj[s][BCD_DIGIT_W*d +: BCD_DIGIT_W])
                );
            end
            assign stg[s+1]       = {adj[s][BCD_W-2:0], bin[bin_width-1-s]};
            assign ovf_chain[s+1] = ovf_chain[s] | adj[s][BCD_W-1];
        end
    endgenerate

    assign in_ready = ~rst;

    always_comb begin
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        if (in_valid && in_ready) begin
            bcd_d       = stg[bin_width];
            overflow_d  = ovf_chain[bin_width];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

`endif

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb/tb_bin_to_bcd.sv - scoreboard bench for bin_to_bcd (default, narrow-overflow and 16-bit instances)
module tb_bin_to_bcd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv0, ir0, ov0, of0;
    logic [7:0]  b0;
    logic [11:0] bcd0;
    logic        iv1, ir1, ov1, of1;
    logic [7:0]  b1;
    logic [7:0]  bcd1;
    logic        iv2, ir2, ov2, of2;
    logic [15:0] b2;
    logic [19:0] bcd2;

    bin_to_bcd #(.bin_width(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .bin(b0),
        .out_valid(ov0), .bcd(bcd0), .overflow(of0)
    );
    bin_to_bcd #(.bin_width(8), .bcd_digits(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .bin(b1),
        .out_valid(ov1), .bcd(bcd1), .overflow(of1)
    );
    bin_to_bcd #(.bin_width(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bin(b2),
        .out_valid(ov2), .bcd(bcd2), .overflow(of2)
    );

    int checks = 0;
    int failures = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];
    logic [32:0] e0, e1, e2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected value from the decimal string: bit 32 = overflow, low digits packed below.
    function automatic logic [32:0] model(input int unsigned v, input int digits);
        string s;
        logic [31:0] r;
        int n;
        r = '0;
        s = $sformatf("%0d", v);
        n = s.len();
        for (int i = 0; i < digits && i < n; i++) begin
            r[4*i +: 4] = 4'(s[n-1-i] - 8'd48);
        end
        return {(n > digits), r};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (q0.size() == 0) check("unexp0", 32'(ov0), 32'd0);
            else if (ov0) begin
                e0 = q0.pop_front();
                check("bcd0", 32'(bcd0), e0[31:0]);
                check("ovf0", 32'(of0), 32'(e0[32]));
            end
            if (q1.size() == 0) check("unexp1", 32'(ov1), 32'd0);
            else if (ov1) begin
                e1 = q1.pop_front();
                check("bcd1", 32'(bcd1), e1[31:0]);
                check("ovf1", 32'(of1), 32'(e1[32]));
            end
            if (q2.size() == 0) check("unexp2", 32'(ov2), 32'd0);
            else if (ov2) begin
                e2 = q2.pop_front();
                check("bcd2", 32'(bcd2), e2[31:0]);
                check("ovf2", 32'(of2), 32'(e2[32]));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send(input int sel, input int unsigned v, input logic [32:0] exp);
        logic rdy;
        logic acc;
        int n;
        acc = 1'b0;
        rdy = 1'b0;
        case (sel)
            0: begin iv0 = 1'b1; b0 = 8'(v); end
            1: begin iv1 = 1'b1; b1 = 8'(v); end
            default: begin iv2 = 1'b1; b2 = 16'(v); end
        endcase
        for (n = 0; n < 100; n++) begin
            rdy = (sel == 0) ? ir0 : (sel == 1) ? ir1 : ir2;
            if (rdy) begin
                acc = 1'b1;
                case (sel)
                    0: q0.push_back(exp);
                    1: q1.push_back(exp);
                    default: q2.push_back(exp);
                endcase
                break;
            end
            @(negedge clk);
        end
        if (!acc) check("ready_tmo", 32'(rdy), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle();
        iv0 = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    int unsigned sv[8] = '{0, 5, 9, 12, 45, 99, 123, 255};
    logic [11:0] se[8] = '{12'h000, 12'h005, 12'h009, 12'h012, 12'h045, 12'h099, 12'h123, 12'h255};
    int lowc;
    int unsigned rv;

    initial begin
        iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
        b0 = '0; b1 = '0; b2 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ovalid", 32'(ov0), 32'd0);
        check("rst_bcd", 32'(bcd0), 32'h000);
        check("rst_ovf", 32'(of0), 32'd0);
        check("rst_ready", 32'(ir0), 32'd1);

        for (int i = 0; i < 8; i++) send(0, sv[i], {1'b0, 20'h0, se[i]});
        idle();
        drain();
        check("bcd_hold", 32'(bcd0), 32'h255);
        check("ovalid_drop", 32'(ov0), 32'd0);

        for (int v = 0; v < 256; v++) send(0, v, model(v, 3));
        idle();
        drain();

        send(1, 255, {1'b1, 32'h55});
        send(1, 99, {1'b0, 32'h99});
        for (int v = 95; v < 106; v++) send(1, v, model(v, 2));
        idle();
        drain();

        send(2, 65535, {1'b0, 32'h65535});
        send(2, 10000, {1'b0, 32'h10000});
        for (int i = 0; i < 20; i++) begin
            rv = $urandom_range(0, 65535);
            send(2, rv, model(rv, 5));
        end
        idle();
        drain();

`ifdef BIN_TO_BCD_SEQ_EN
        iv0 = 1'b1;
        b0 = 8'd200;
        check("seq_ready_idle", 32'(ir0), 32'd1);
        q0.push_back({1'b0, 32'h200});
        @(negedge clk);
        lowc = 0;
        for (int n = 0; n < 40 && !ir0; n++) begin
            lowc++;
            @(negedge clk);
        end
        iv0 = 1'b0;
        check("seq_busy", 32'(lowc), 32'd8);
        check("seq_pulse", 32'(ov0), 32'd1);
        @(negedge clk);
        check("seq_pulse_end", 32'(ov0), 32'd0);
        drain();
`endif

        send(0, 17, model(17, 3));
        send(0, 18, model(18, 3));
        rst = 1'b1;
        repeat (2) @(negedge clk);
        q0.delete();
        q1.delete();
        q2.delete();
        idle();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ovalid", 32'(ov0), 32'd0);
        check("mid_rst_bcd", 32'(bcd0), 32'h000);
        check("mid_rst_ready", 32'(ir0), 32'd1);
        send(0, 42, {1'b0, 32'h042});
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
